// File: rtl/pkt_verdict_filter_pkg.sv
// Shared definitions for the store-and-forward packet verdict filter:
// verdict layout, ingress/egress state encodings and a verdict builder.
package pkt_filter_pkg;

    localparam int VERDICT_WBITS    = 2;
    localparam int VERDICT_BAD      = 0;
    localparam int VERDICT_OVERSIZE = 1;

    typedef enum logic [0:0] {
        ING_ACCEPT  = 1'b0,
        ING_DISCARD = 1'b1
    } ing_state_e;

    typedef enum logic [1:0] {
        EG_IDLE = 2'b00,
        EG_PASS = 2'b01,
        EG_DROP = 2'b10
    } eg_state_e;

    function automatic logic [VERDICT_WBITS-1:0] make_verdict(
        input logic oversize,
        input logic bad
    );
        logic [VERDICT_WBITS-1:0] v;
        v                   = {VERDICT_WBITS{1'b0}};
        v[VERDICT_OVERSIZE] = oversize;
        v[VERDICT_BAD]      = bad;
        return v;
    endfunction

endpackage

// File: rtl/pkt_verdict_filter_sync_fifo.sv
// First-word fall-through synchronous FIFO. The head word is visible on
// o_rd_data whenever o_empty is low; i_rd_en pops it.
module sync_fifo
    import pkt_filter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; storage contents need no reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/pkt_verdict_filter.sv
// Store-and-forward AXI-Stream filter: packets are buffered whole, judged on
// their last beat (TUSER mask or length) and then forwarded or drained.
module pkt_verdict_filter
    import pkt_filter_pkg::*;
#(
    parameter int DATA_WBITS    = 512,
    parameter int USER_WBITS    = 4,
    parameter int FIFO_DEPTH    = 256,
    parameter int VFIFO_DEPTH   = 32,
    parameter int MAX_PKT_BEATS = 64,
    parameter int CNT_WBITS     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [USER_WBITS-1:0]   drop_mask,
    input  logic                    clear_stats,
    output logic                    overrun,
    output logic [CNT_WBITS-1:0]    pass_count,
    output logic [CNT_WBITS-1:0]    drop_count,
    output logic [CNT_WBITS-1:0]    oversize_count,
    input  logic [DATA_WBITS-1:0]   AXIS_IN_TDATA,
    input  logic [DATA_WBITS/8-1:0] AXIS_IN_TKEEP,
    input  logic [USER_WBITS-1:0]   AXIS_IN_TUSER,
    input  logic                    AXIS_IN_TLAST,
    input  logic                    AXIS_IN_TVALID,
    output logic                    AXIS_IN_TREADY,
    output logic [DATA_WBITS-1:0]   AXIS_OUT_TDATA,
    output logic [DATA_WBITS/8-1:0] AXIS_OUT_TKEEP,
    output logic                    AXIS_OUT_TLAST,
    output logic                    AXIS_OUT_TVALID,
    input  logic                    AXIS_OUT_TREADY
);

    localparam int DATA_WBYTS = DATA_WBITS / 8;
    localparam int DF_WBITS   = 1 + DATA_WBYTS + DATA_WBITS;
    localparam int BCNT_WBITS = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BCNT_WBITS-1:0] BCNT_ONE  = {{(BCNT_WBITS-1){1'b0}}, 1'b1};
    localparam logic [BCNT_WBITS-1:0] LAST_IDX  = BCNT_WBITS'(MAX_PKT_BEATS - 1);
    localparam logic [CNT_WBITS-1:0]  CNT_ONE   = {{(CNT_WBITS-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WBITS-1:0] sat_inc(
        input logic [CNT_WBITS-1:0] c,
        input logic                 inc
    );
        if (inc && !(&c)) begin
            return c + CNT_ONE;
        end else begin
            return c;
        end
    endfunction

    ing_state_e              r_ing_state;
    eg_state_e               r_eg_state;
    logic [BCNT_WBITS-1:0]   r_beat_cnt;
    logic                    r_cur_oversize;
    logic                    r_overrun;
    logic [CNT_WBITS-1:0]    r_pass_cnt;
    logic [CNT_WBITS-1:0]    r_drop_cnt;
    logic [CNT_WBITS-1:0]    r_over_cnt;

    logic                    w_in_ready;
    logic                    w_in_hs;
    logic                    w_dfifo_wr;
    logic                    w_wr_last;
    logic                    w_vfifo_wr;
    logic [VERDICT_WBITS-1:0] w_verdict_in;
    logic [DF_WBITS-1:0]     w_dfifo_wdata;
    logic [DF_WBITS-1:0]     w_dfifo_rdata;
    logic                    w_dfifo_full;
    logic                    w_dfifo_empty;
    logic                    w_dfifo_rd;
    logic [VERDICT_WBITS-1:0] w_verdict_out;
    logic                    w_vfifo_full;
    logic                    w_vfifo_empty;
    logic                    w_vfifo_rd;
    logic                    w_head_last;
    logic                    w_out_valid;
    logic                    w_pass_inc;
    logic                    w_drop_inc;
    logic                    w_over_inc;

    // DISCARD swallows the tail of a truncated packet without buffering it.
    assign w_in_ready = ~reset & ((r_ing_state == ING_DISCARD) |
                                  (~w_dfifo_full & ~w_vfifo_full));
    assign w_in_hs    = AXIS_IN_TVALID & w_in_ready;

    // Ingress write decode: data beat, forced TLAST and verdict push.
    always_comb begin
        w_dfifo_wr   = 1'b0;
        w_vfifo_wr   = 1'b0;
        w_wr_last    = AXIS_IN_TLAST;
        w_verdict_in = make_verdict(1'b0, 1'b0);
        if ((r_ing_state == ING_ACCEPT) && w_in_hs) begin
            w_dfifo_wr = 1'b1;
            if (AXIS_IN_TLAST) begin
                w_vfifo_wr   = 1'b1;
                w_verdict_in = make_verdict(1'b0, |(AXIS_IN_TUSER & drop_mask));
            end else if (r_beat_cnt == LAST_IDX) begin
                w_vfifo_wr   = 1'b1;
                w_wr_last    = 1'b1;
                w_verdict_in = make_verdict(1'b1, 1'b1);
            end else begin
                w_vfifo_wr   = 1'b0;
            end
        end else begin
            w_dfifo_wr = 1'b0;
        end
    end

    assign w_dfifo_wdata = {w_wr_last, AXIS_IN_TKEEP, AXIS_IN_TDATA};

    // Ingress FSM and per-packet beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ing_state <= ING_ACCEPT;
            r_beat_cnt  <= {BCNT_WBITS{1'b0}};
        end else begin
            case (r_ing_state)
                ING_ACCEPT: begin
                    if (w_in_hs) begin
                        if (AXIS_IN_TLAST) begin
                            r_beat_cnt <= {BCNT_WBITS{1'b0}};
                        end else if (r_beat_cnt == LAST_IDX) begin
                            r_beat_cnt  <= {BCNT_WBITS{1'b0}};
                            r_ing_state <= ING_DISCARD;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BCNT_ONE;
                        end
                    end
                end
                ING_DISCARD: begin
                    if (w_in_hs && AXIS_IN_TLAST) begin
                        r_ing_state <= ING_ACCEPT;
                    end
                end
                default: begin
                    r_ing_state <= ING_ACCEPT;
                    r_beat_cnt  <= {BCNT_WBITS{1'b0}};
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DF_WBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_dfifo (
        .clk       (clk),
        .i_reset   (reset),
        .i_wr_en   (w_dfifo_wr),
        .i_wr_data (w_dfifo_wdata),
        .i_rd_en   (w_dfifo_rd),
        .o_rd_data (w_dfifo_rdata),
        .o_full    (w_dfifo_full),
        .o_empty   (w_dfifo_empty)
    );

    sync_fifo #(
        .WIDTH (VERDICT_WBITS),
        .DEPTH (VFIFO_DEPTH)
    ) u_vfifo (
        .clk       (clk),
        .i_reset   (reset),
        .i_wr_en   (w_vfifo_wr),
        .i_wr_data (w_verdict_in),
        .i_rd_en   (w_vfifo_rd),
        .o_rd_data (w_verdict_out),
        .o_full    (w_vfifo_full),
        .o_empty   (w_vfifo_empty)
    );

    assign w_head_last = w_dfifo_rdata[DF_WBITS-1];

    // Egress pop decode; DROP drains one beat per cycle ignoring the sink.
    always_comb begin
        w_vfifo_rd  = 1'b0;
        w_dfifo_rd  = 1'b0;
        w_out_valid = 1'b0;
        case (r_eg_state)
            EG_IDLE: begin
                w_vfifo_rd = ~w_vfifo_empty;
            end
            EG_PASS: begin
                w_out_valid = ~w_dfifo_empty;
                w_dfifo_rd  = ~w_dfifo_empty & AXIS_OUT_TREADY;
            end
            EG_DROP: begin
                w_dfifo_rd = ~w_dfifo_empty;
            end
            default: begin
                w_vfifo_rd  = 1'b0;
                w_dfifo_rd  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign w_pass_inc = (r_eg_state == EG_PASS) & w_dfifo_rd & w_head_last;
    assign w_drop_inc = (r_eg_state == EG_DROP) & w_dfifo_rd & w_head_last;
    assign w_over_inc = w_drop_inc & r_cur_oversize;

    // Egress FSM: fetch a verdict, then forward or drain exactly one packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_eg_state     <= EG_IDLE;
            r_cur_oversize <= 1'b0;
        end else begin
            case (r_eg_state)
                EG_IDLE: begin
                    if (!w_vfifo_empty) begin
                        r_cur_oversize <= w_verdict_out[VERDICT_OVERSIZE];
                        r_eg_state     <= w_verdict_out[VERDICT_BAD] ? EG_DROP : EG_PASS;
                    end
                end
                EG_PASS: begin
                    if (w_pass_inc) begin
                        r_eg_state <= EG_IDLE;
                    end
                end
                EG_DROP: begin
                    if (w_drop_inc) begin
                        r_eg_state <= EG_IDLE;
                    end
                end
                default: begin
                    r_eg_state     <= EG_IDLE;
                    r_cur_oversize <= 1'b0;
                end
            endcase
        end
    end

    // Statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            r_pass_cnt <= {CNT_WBITS{1'b0}};
            r_drop_cnt <= {CNT_WBITS{1'b0}};
            r_over_cnt <= {CNT_WBITS{1'b0}};
        end else begin
            r_pass_cnt <= sat_inc(r_pass_cnt, w_pass_inc);
            r_drop_cnt <= sat_inc(r_drop_cnt, w_drop_inc);
            r_over_cnt <= sat_inc(r_over_cnt, w_over_inc);
        end
    end

    // Back-pressure indicator, one cycle behind the stalled offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= AXIS_IN_TVALID & ~w_in_ready;
        end
    end

    assign AXIS_IN_TREADY  = w_in_ready;
    assign AXIS_OUT_TDATA  = w_dfifo_rdata[DATA_WBITS-1:0];
    assign AXIS_OUT_TKEEP  = w_dfifo_rdata[DATA_WBITS +: DATA_WBYTS];
    assign AXIS_OUT_TLAST  = w_head_last;
    assign AXIS_OUT_TVALID = w_out_valid & ~reset;
    assign overrun         = r_overrun;
    assign pass_count      = r_pass_cnt;
    assign drop_count      = r_drop_cnt;
    assign oversize_count  = r_over_cnt;

endmodule

// File: tb/tb_pkt_verdict_filter.sv
// Randomised and directed bench for pkt_verdict_filter, scored against a
// packet-level reference model (whole-packet queues and plain counters).
module tb_pkt_verdict_filter;

    localparam int DW   = 64;
    localparam int KW   = DW / 8;
    localparam int UW   = 4;
    localparam int FD   = 256;
    localparam int VD   = 32;
    localparam int MAXB = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int KMAX = (1 << KW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [UW-1:0]   drop_mask = '0;
    logic            clear_stats = 1'b0;
    logic            overrun;
    logic [CW-1:0]   pass_count, drop_count, oversize_count;
    logic [DW-1:0]   AXIS_IN_TDATA = '0;
    logic [KW-1:0]   AXIS_IN_TKEEP = '0;
    logic [UW-1:0]   AXIS_IN_TUSER = '0;
    logic            AXIS_IN_TLAST = 1'b0;
    logic            AXIS_IN_TVALID = 1'b0;
    logic            AXIS_IN_TREADY;
    logic [DW-1:0]   AXIS_OUT_TDATA;
    logic [KW-1:0]   AXIS_OUT_TKEEP;
    logic            AXIS_OUT_TLAST;
    logic            AXIS_OUT_TVALID;
    logic            AXIS_OUT_TREADY = 1'b1;

    always #5 clk = ~clk;

    pkt_verdict_filter #(
        .DATA_WBITS(DW), .USER_WBITS(UW), .FIFO_DEPTH(FD),
        .VFIFO_DEPTH(VD), .MAX_PKT_BEATS(MAXB), .CNT_WBITS(CW)
    ) dut (
        .clk(clk), .reset(reset), .drop_mask(drop_mask), .clear_stats(clear_stats),
        .overrun(overrun), .pass_count(pass_count), .drop_count(drop_count),
        .oversize_count(oversize_count),
        .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TKEEP(AXIS_IN_TKEEP),
        .AXIS_IN_TUSER(AXIS_IN_TUSER), .AXIS_IN_TLAST(AXIS_IN_TLAST),
        .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
        .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TKEEP(AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST(AXIS_OUT_TLAST), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY(AXIS_OUT_TREADY)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur_q[$];
    int    exp_pass, exp_drop, exp_over;
    bit    discarding;
    int    n_in_hs, n_out_hs;
    int    n_tests, n_fail;
    bit    tx_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int v);
        if (v > CMAX) return 64'(CMAX);
        else          return 64'(v);
    endfunction

    // Packet-level reference: collect beats, decide the packet's fate at its end.
    task automatic model_in(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [UW-1:0] u, input logic l, input logic [UW-1:0] m);
        beat_t b;
        if (discarding) begin
            if (l) discarding = 1'b0;
            return;
        end
        b.d = d; b.k = k; b.l = l;
        cur_q.push_back(b);
        if (l) begin
            if ((u & m) != '0) begin
                exp_drop++;
            end else begin
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                exp_pass++;
            end
            cur_q.delete();
        end else if (cur_q.size() == MAXB) begin
            exp_drop++;
            exp_over++;
            cur_q.delete();
            discarding = 1'b1;
        end
    endtask

    task automatic monitor();
        bit            prev_stall_in = 1'b0, prev_reset = 1'b1, prev_out_stall = 1'b0, seen = 1'b0;
        logic [DW-1:0] hd;
        logic [KW-1:0] hk;
        logic          hl;
        beat_t         e;
        forever begin
            @(negedge clk);
            if (seen) check_eq("overrun", 64'(overrun), 64'(!prev_reset && prev_stall_in));
            if (reset) begin
                exp_q.delete(); cur_q.delete(); discarding = 1'b0;
                exp_pass = 0; exp_drop = 0; exp_over = 0;
                prev_out_stall = 1'b0;
            end else begin
                if (clear_stats) begin
                    exp_pass = 0; exp_drop = 0; exp_over = 0;
                end
                if (prev_out_stall) begin
                    check_eq("hold_valid", 64'(AXIS_OUT_TVALID), 64'd1);
                    check_eq("hold_data",  64'(AXIS_OUT_TDATA), 64'(hd));
                    check_eq("hold_keep",  64'(AXIS_OUT_TKEEP), 64'(hk));
                    check_eq("hold_last",  64'(AXIS_OUT_TLAST), 64'(hl));
                end
                if (AXIS_IN_TVALID && AXIS_IN_TREADY) begin
                    n_in_hs++;
                    model_in(AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TUSER, AXIS_IN_TLAST, drop_mask);
                end
                if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                    n_out_hs++;
                    check_eq("out_beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("out_data", 64'(AXIS_OUT_TDATA), 64'(e.d));
                        check_eq("out_keep", 64'(AXIS_OUT_TKEEP), 64'(e.k));
                        check_eq("out_last", 64'(AXIS_OUT_TLAST), 64'(e.l));
                    end
                end
                prev_out_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
                hd = AXIS_OUT_TDATA; hk = AXIS_OUT_TKEEP; hl = AXIS_OUT_TLAST;
            end
            prev_stall_in = AXIS_IN_TVALID && !AXIS_IN_TREADY;
            prev_reset    = reset;
            seen          = 1'b1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                              input logic [UW-1:0] u, input logic l, output bit ok);
        int w = 0;
        AXIS_IN_TDATA = d; AXIS_IN_TKEEP = k; AXIS_IN_TUSER = u;
        AXIS_IN_TLAST = l; AXIS_IN_TVALID = 1'b1;
        @(negedge clk);
        while (!AXIS_IN_TREADY && w < 3000) begin
            @(negedge clk);
            w++;
        end
        ok = AXIS_IN_TREADY;
        if (!ok) check_eq("in_ready_timeout", 64'(AXIS_IN_TREADY), 64'd1);
        @(posedge clk); #1;
        AXIS_IN_TVALID = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [UW-1:0] u, input int gap_pct);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                @(posedge clk); #1;
            end
            drive_beat({$urandom, $urandom}, KW'($urandom_range(1, KMAX)),
                       (i == n - 1) ? u : UW'($urandom), (i == n - 1), ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        AXIS_OUT_TREADY = 1'b1;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (400) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_pass"}, 64'(pass_count),     sat(exp_pass));
        check_eq({tag, "_drop"}, 64'(drop_count),     sat(exp_drop));
        check_eq({tag, "_over"}, 64'(oversize_count), sat(exp_over));
    endtask

    initial begin
        int  base;
        int  w;
        bit  ok;
        fork
            monitor();
            begin
                #900000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready",  64'(AXIS_IN_TREADY), 64'd0);
        check_eq("rst_out_valid", 64'(AXIS_OUT_TVALID), 64'd0);
        check_eq("rst_overrun",   64'(overrun), 64'd0);
        check_eq("rst_pass",      64'(pass_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: three-beat good packet
        drop_mask = 4'hF;
        base = n_out_hs;
        send_pkt(3, 4'h0, 0);
        wait_drain();
        check_eq("t1_beats", 64'(n_out_hs - base), 64'd3);
        check_eq("t1_pass",  64'(pass_count), 64'd1);
        check_counts("t1");

        // 2: masked error drops A, B passes
        pulse_clear();
        drop_mask = 4'h2;
        base = n_out_hs;
        send_pkt(2, 4'h2, 0);
        send_pkt(3, 4'h0, 0);
        wait_drain();
        check_eq("t2_beats", 64'(n_out_hs - base), 64'd3);
        check_eq("t2_drop",  64'(drop_count), 64'd1);
        check_counts("t2");

        // 3: oversize packet truncated and dropped, next packet intact
        pulse_clear();
        drop_mask = 4'h0;
        base = n_out_hs;
        send_pkt(70, 4'h0, 0);
        send_pkt(2, 4'h0, 0);
        wait_drain();
        check_eq("t3_beats", 64'(n_out_hs - base), 64'd2);
        check_eq("t3_over",  64'(oversize_count), 64'd1);
        check_counts("t3");

        // 4: sink stalled, FIFO fills at its depth, then releases in order
        pulse_clear();
        AXIS_OUT_TREADY = 1'b0;
        base = n_in_hs;
        w = n_out_hs;
        fork
            for (int p = 0; p < 10; p++) send_pkt(30, 4'h0, 0);
            begin
                int t = 0;
                while ((n_in_hs - base) < FD && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (2) @(negedge clk);
                check_eq("t4_stored",   64'(n_in_hs - base), 64'(FD));
                check_eq("t4_in_ready", 64'(AXIS_IN_TREADY), 64'd0);
                check_eq("t4_overrun",  64'(overrun), 64'd1);
                @(posedge clk); #1;
                AXIS_OUT_TREADY = 1'b1;
            end
        join
        wait_drain();
        check_eq("t4_beats", 64'(n_out_hs - w), 64'd300);
        check_counts("t4");

        // 5: reset in the middle of a packet
        for (int i = 0; i < 4; i++) begin
            drive_beat({$urandom, $urandom}, KW'(KMAX), 4'h0, 1'b0, ok);
        end
        AXIS_IN_TVALID = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t5_in_ready",  64'(AXIS_IN_TREADY), 64'd0);
        check_eq("t5_out_valid", 64'(AXIS_OUT_TVALID), 64'd0);
        check_eq("t5_overrun",   64'(overrun), 64'd0);
        check_eq("t5_pass",      64'(pass_count), 64'd0);
        check_eq("t5_drop",      64'(drop_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        base = n_out_hs;
        send_pkt(1, 4'h0, 0);
        wait_drain();
        check_eq("t5_beats", 64'(n_out_hs - base), 64'd1);
        check_counts("t5");

        // 6: clear coincident with a pass increment, then saturation
        pulse_clear();
        AXIS_OUT_TREADY = 1'b0;
        send_pkt(1, 4'h0, 0);
        w = 0;
        while (!AXIS_OUT_TVALID && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("t6_valid_wait", 64'(AXIS_OUT_TVALID), 64'd1);
        @(posedge clk); #1;
        AXIS_OUT_TREADY = 1'b1;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        @(negedge clk);
        check_eq("t6_clear_wins", 64'(pass_count), 64'd0);
        @(posedge clk); #1;
        for (int p = 0; p < 20; p++) send_pkt(1, 4'h0, 0);
        wait_drain();
        check_eq("t6_saturate", 64'(pass_count), 64'(CMAX));
        check_counts("t6");

        // Randomised traffic: mixed lengths, errors, masks, gaps and sink stalls
        for (int r = 0; r < 5; r++) begin
            pulse_clear();
            tx_done = 1'b0;
            fork
                begin
                    for (int p = 0; p < 12; p++) begin
                        int len;
                        drop_mask = UW'($urandom);
                        if ($urandom_range(0, 9) == 0) len = int'($urandom_range(60, 80));
                        else                           len = int'($urandom_range(1, 12));
                        send_pkt(len, UW'($urandom), 20);
                    end
                    tx_done = 1'b1;
                end
                begin
                    while (!tx_done) begin
                        @(posedge clk); #1;
                        AXIS_OUT_TREADY = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            wait_drain();
            check_counts("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
